mem_xfer_unit: RTL and testbench

MEM_XFER_UNIT -- requirements
Module: mem_xfer_unit

---
 rtl/mem_xfer_unit.sv | 104 ++++++++++
 tb/tb_mem_xfer_unit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mem_xfer_unit.sv
// mem_xfer_unit: moves one cache line between a latched line buffer and word-wide
// memory, one acknowledged beat at a time, with a one-cycle gap between beats.
module mem_xfer_unit #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 16,
   parameter int LINE_WORDS = 4,
   parameter int BEAT_W     = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         mem_enable,
   input  logic                         rd_wrt_mem,
   input  logic [ADDR_W-1:0]            line_addr,
   input  logic [LINE_WORDS*DATA_W-1:0] wb_data,
   output logic [LINE_WORDS*DATA_W-1:0] fill_data,
   output logic                         done_mem,
   output logic                         busy,
   output logic                         m_req,
   output logic                         m_we,
   output logic [ADDR_W-1:0]            m_addr,
   output logic [DATA_W-1:0]            m_wdata,
   input  logic [DATA_W-1:0]            m_rdata,
   input  logic                         m_ack
);
   typedef enum logic [1:0] {IDLE, BEAT, NEXT, DONE} state_t;
   state_t                       state_q, state_d;
   logic [BEAT_W-1:0]            beat_q, beat_d;
   logic                         mode_q, mode_d;
   logic [ADDR_W-1:0]            base_q, base_d;
   logic [LINE_WORDS*DATA_W-1:0] buf_q, buf_d, fill_q, fill_d;
   logic                         last;
   logic                         req_d, we_d;
   logic [ADDR_W-1:0]            addr_d;
   logic [DATA_W-1:0]            wdata_d;
   logic                         req_q, we_q, done_q, busy_q;
   logic [ADDR_W-1:0]            addr_q;
   logic [DATA_W-1:0]            wdata_q;
   assign last = beat_q == BEAT_W'(LINE_WORDS - 1);
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      mode_d  = mode_q;
      base_d  = base_q;
      buf_d   = buf_q;
      fill_d  = fill_q;
      case (state_q)
         IDLE: if (mem_enable) begin
            state_d = BEAT;
            beat_d  = '0;
            mode_d  = rd_wrt_mem;
            base_d  = {line_addr[ADDR_W-1:BEAT_W], {BEAT_W{1'b0}}};
            buf_d   = wb_data;
         end
         BEAT: if (m_ack) begin
            if (mode_q) fill_d[int'(beat_q)*DATA_W +: DATA_W] = m_rdata;
            state_d = last ? DONE : NEXT;
            beat_d  = last ? beat_q : beat_q + 1'b1;
         end
         NEXT:    state_d = BEAT;
         default: state_d = IDLE;
      endcase
   end
   // Bus outputs are registered from the next-state values so they track the state register exactly.
   assign req_d   = state_d == BEAT;
   assign we_d    = req_d & ~mode_d;
   assign addr_d  = req_d ? (base_d | ADDR_W'(beat_d)) : '0;
   assign wdata_d = we_d ? buf_d[int'(beat_d)*DATA_W +: DATA_W] : '0;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         beat_q  <= '0;
         mode_q  <= 1'b0;
         base_q  <= '0;
         buf_q   <= '0;
         fill_q  <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         mode_q  <= mode_d;
         base_q  <= base_d;
         buf_q   <= buf_d;
         fill_q  <= fill_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         done_q  <= state_d == DONE;
         busy_q  <= state_d != IDLE;
      end
   end
   assign fill_data = fill_q;
   assign done_mem  = done_q;
   assign busy      = busy_q;
   assign m_req     = req_q;
   assign m_we      = we_q;
   assign m_addr    = addr_q;
   assign m_wdata   = wdata_q;
endmodule

// File: tb/tb_mem_xfer_unit.sv
// tb_mem_xfer_unit: randomized line transfers checked against a transaction-level model
// of beat addresses, write data, fill contents and accept-to-done latency.
module tb_mem_xfer_unit;
   logic        clk = 1'b0, rst = 1'b0, mem_enable = 1'b0, rd_wrt_mem = 1'b0, m_ack = 1'b0;
   logic [15:0] line_addr = '0, m_rdata = '0;
   logic [15:0] m_addr, m_wdata;
   logic [63:0] wb_data = '0;
   logic [63:0] fill_data;
   logic        done_mem, busy, m_req, m_we;
   int          total = 0, bad = 0;
   logic [63:0] exp_fill = '0;
   bit          after_done = 1'b0, use_pat = 1'b0;
   int          waits [4];

   mem_xfer_unit dut (
      .clk(clk), .rst(rst), .mem_enable(mem_enable), .rd_wrt_mem(rd_wrt_mem),
      .line_addr(line_addr), .wb_data(wb_data), .fill_data(fill_data),
      .done_mem(done_mem), .busy(busy), .m_req(m_req), .m_we(m_we),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle_ack(input bit spur);
      m_ack   = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      m_rdata = 16'($urandom);
   endtask

   task automatic xfer(input bit mode, input logic [15:0] addr, input logic [63:0] wb,
                       input bit hold, input bit spur, input int abort_beat);
      logic [15:0] base, rd;
      int idle = 0, n = 1, bi = 0, wc = 0, lat = 4;
      base = addr & 16'hFFFC;
      for (int k = 0; k < 4; k++) lat += waits[k] + 1;
      rd_wrt_mem = mode;
      line_addr  = addr;
      wb_data    = wb;
      mem_enable = 1'b1;
      @(negedge clk);
      while (!busy && idle < 8) begin
         check("idle_done", done_mem, 0);
         idle_ack(spur);
         idle++;
         @(negedge clk);
      end
      check("accept_gap", idle, after_done ? 1 : 0);
      if (!hold) mem_enable = 1'b0;
      rd_wrt_mem = ~mode;
      line_addr  = 16'($urandom);
      wb_data    = {$urandom, $urandom};
      while (n <= lat + 4) begin
         if (m_req && bi < 4) begin
            if (bi == abort_beat) begin
               rst = 1'b0;
               #1;
               check("abort_outs", {done_mem, busy, m_req, m_we, m_addr, m_wdata}, 0);
               check("abort_fill", fill_data, 0);
               exp_fill = '0;
               repeat (2) begin
                  @(negedge clk);
                  check("abort_hold", {done_mem, busy, m_req}, 0);
               end
               rst = 1'b1;
               after_done = 1'b0;
               return;
            end
            check("m_addr", m_addr, base + 16'(bi));
            check("m_we", m_we, !mode);
            check("m_wdata", m_wdata, mode ? 16'h0 : wb[bi*16 +: 16]);
            if (wc == waits[bi]) begin
               rd = use_pat ? 16'hA000 + base + 16'(bi) : 16'($urandom);
               m_ack   = 1'b1;
               m_rdata = rd;
               if (mode) exp_fill[bi*16 +: 16] = rd;
               bi++;
               wc = 0;
            end else begin
               m_ack   = 1'b0;
               m_rdata = 16'($urandom);
               wc++;
            end
         end else begin
            if (m_req) check("extra_beat", bi, 3);
            idle_ack(spur);
         end
         if (done_mem) break;
         check("busy", busy, 1);
         @(negedge clk);
         n++;
      end
      check("latency", n, lat);
      check("beats", bi, 4);
      check("fill", fill_data, exp_fill);
      check("done_busy", busy, 1);
      after_done = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      #1;
      check("rst_outs", {done_mem, busy, m_req, m_we, m_addr, m_wdata}, 0);
      check("rst_fill", fill_data, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      waits = '{0, 0, 0, 0};
      use_pat = 1'b1;
      xfer(1'b1, 16'h0107, 64'h0, 1'b0, 1'b0, -1);
      check("fill_0107", fill_data, 64'hA107_A106_A105_A104);
      use_pat = 1'b0;
      waits = '{2, 2, 2, 2};
      xfer(1'b0, 16'h0020, 64'h4444_3333_2222_1111, 1'b0, 1'b0, -1);
      check("wb_keeps_fill", fill_data, 64'hA107_A106_A105_A104);
      waits = '{0, 0, 0, 0};
      xfer(1'b1, 16'($urandom), {$urandom, $urandom}, 1'b1, 1'b0, -1);
      xfer(1'b1, 16'($urandom), {$urandom, $urandom}, 1'b1, 1'b0, -1);
      xfer(1'b0, 16'($urandom), {$urandom, $urandom}, 1'b0, 1'b0, -1);
      for (int t = 0; t < 20; t++) begin
         for (int k = 0; k < 4; k++) waits[k] = $urandom_range(0, 3);
         xfer(1'($urandom_range(0, 1)), 16'($urandom), {$urandom, $urandom}, 1'b0, 1'b1, -1);
      end
      for (int k = 0; k < 4; k++) waits[k] = $urandom_range(0, 2);
      xfer(1'b1, 16'($urandom), {$urandom, $urandom}, 1'b0, 1'b1, 2);
      xfer(1'b1, 16'($urandom), {$urandom, $urandom}, 1'b0, 1'b0, -1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
